// File: rtl/ysyx_25040129_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25040129_mem_arbiter
//   Shares one AXI4-Lite-style memory port between the IFU (m0, read only)
//   and the LSU (m1, read + write). One transaction is granted at a time.
//   The grant is decided in IDLE, registered, and held until the response
//   handshake completes. Channel routing is purely combinational from the
//   registered grant state; no address or data is buffered.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : round-robin between m0 and m1 using a 1-bit last_grant_r
//     undefined : fixed priority, LSU (m1) over IFU (m0)
// ----------------------------------------------------------------------------
module ysyx_25040129_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // IFU read
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [2:0]          m0_arsize,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   // LSU read
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [2:0]          m1_arsize,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   // LSU write
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   // Slave side
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [2:0]          s_arsize,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_M0 = 2'd1,
      RD_M1 = 2'd2,
      WR_M1 = 2'd3
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   logic req0_s;
   logic req1r_s;
   logic req1w_s;
   logic rd_done_s;
   logic wr_done_s;

   assign req0_s    = m0_arvalid;
   assign req1r_s   = m1_arvalid;
   assign req1w_s   = m1_awvalid | m1_wvalid;
   // s_rready / s_bready are already zero outside the matching state.
   assign rd_done_s = s_rvalid & s_rready;
   assign wr_done_s = s_bvalid & s_bready;

   // Grant state register; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // last_grant_r: 1 = m1 granted last, 0 = m0 granted last (so m1 wins the first tie).
   logic last_grant_r;

   // Remember which master received the most recent grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= 1'b0;
      end else if ((state_r == IDLE) && (state_nxt_s != IDLE)) begin
         last_grant_r <= (state_nxt_s != RD_M0);
      end else begin
         last_grant_r <= last_grant_r;
      end
   end
`endif

   // Next-state: arbitrate in IDLE, otherwise wait for the response handshake.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
            if ((req1r_s || req1w_s) && req0_s) begin
               if (last_grant_r) begin
                  state_nxt_s = RD_M0;
               end else if (req1r_s) begin
                  state_nxt_s = RD_M1;
               end else begin
                  state_nxt_s = WR_M1;
               end
            end else if (req1r_s) begin
               state_nxt_s = RD_M1;
            end else if (req1w_s) begin
               state_nxt_s = WR_M1;
            end else if (req0_s) begin
               state_nxt_s = RD_M0;
            end else begin
               state_nxt_s = IDLE;
            end
`else
            // LSU first so it is never starved while the IFU waits on it.
            if (req1r_s) begin
               state_nxt_s = RD_M1;
            end else if (req1w_s) begin
               state_nxt_s = WR_M1;
            end else if (req0_s) begin
               state_nxt_s = RD_M0;
            end else begin
               state_nxt_s = IDLE;
            end
`endif
         end
         RD_M0: begin
            if (rd_done_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RD_M0;
            end
         end
         RD_M1: begin
            if (rd_done_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RD_M1;
            end
         end
         WR_M1: begin
            if (wr_done_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WR_M1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Channel routing: everything idles at zero, the granted master's channels are connected.
   always_comb begin
      m0_arready = 1'b0;
      m0_rdata   = {DATA_W{1'b0}};
      m0_rresp   = 2'b00;
      m0_rvalid  = 1'b0;
      m1_arready = 1'b0;
      m1_rdata   = {DATA_W{1'b0}};
      m1_rresp   = 2'b00;
      m1_rvalid  = 1'b0;
      m1_awready = 1'b0;
      m1_wready  = 1'b0;
      m1_bresp   = 2'b00;
      m1_bvalid  = 1'b0;
      s_araddr   = {ADDR_W{1'b0}};
      s_arsize   = 3'b000;
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      s_awaddr   = {ADDR_W{1'b0}};
      s_awvalid  = 1'b0;
      s_wdata    = {DATA_W{1'b0}};
      s_wstrb    = {STRB_W{1'b0}};
      s_wvalid   = 1'b0;
      s_bready   = 1'b0;
      case (state_r)
         IDLE: begin
            s_arvalid = 1'b0;
         end
         RD_M0: begin
            s_araddr   = m0_araddr;
            s_arsize   = m0_arsize;
            s_arvalid  = m0_arvalid;
            m0_arready = s_arready;
            m0_rdata   = s_rdata;
            m0_rresp   = s_rresp;
            m0_rvalid  = s_rvalid;
            s_rready   = m0_rready;
         end
         RD_M1: begin
            s_araddr   = m1_araddr;
            s_arsize   = m1_arsize;
            s_arvalid  = m1_arvalid;
            m1_arready = s_arready;
            m1_rdata   = s_rdata;
            m1_rresp   = s_rresp;
            m1_rvalid  = s_rvalid;
            s_rready   = m1_rready;
         end
         WR_M1: begin
            // aw and w are independent; either may complete first.
            s_awaddr   = m1_awaddr;
            s_awvalid  = m1_awvalid;
            m1_awready = s_awready;
            s_wdata    = m1_wdata;
            s_wstrb    = m1_wstrb;
            s_wvalid   = m1_wvalid;
            m1_wready  = s_wready;
            m1_bresp   = s_bresp;
            m1_bvalid  = s_bvalid;
            s_bready   = m1_bready;
         end
         default: begin
            s_arvalid = 1'b0;
         end
      endcase
   end

endmodule
